// File: rtl/instruction_assembler.sv
// Packs decoded I/L/S/B instruction fields into RV32 words and streams them
// into instruction memory at an auto-incrementing byte address.
module instruction_assembler #(
  parameter int unsigned INTRSIZE   = 32,
  parameter int unsigned IMMSIZE    = 32,
  parameter int unsigned ADDRSIZE   = 32,
  parameter int unsigned ERRCNTSIZE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDRSIZE-1:0]   base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [IMMSIZE-1:0]    in_imm,
  output logic                  imem_we,
  output logic [ADDRSIZE-1:0]   imem_addr,
  output logic [INTRSIZE-1:0]   imem_wdata,
  input  logic                  imem_ready,
  output logic                  done,
  output logic                  err_flag,
  output logic [ERRCNTSIZE-1:0] err_count
);

  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDRSIZE-1:0]   ptr_q, ptr_d;
  logic [ADDRSIZE-1:0]   ptr_inc;
  logic                  we_d;
  logic [ADDRSIZE-1:0]   addr_d;
  logic [INTRSIZE-1:0]   wdata_d;
  logic                  done_d;
  logic                  errf_d;
  logic [ERRCNTSIZE-1:0] errc_d;
  logic [31:0]           word;
  logic                  op_ok;
  logic                  imm_ok;
  logic                  fire;
  logic                  wr_hs;

  assign in_ready = (state_q == S_RUN) && (!imem_we || imem_ready);
  assign fire     = in_valid && in_ready;
  assign wr_hs    = imem_we && imem_ready;
  assign ptr_inc  = ptr_q + ADDRSIZE'(4);
  // Immediate must fit a signed 12-bit field: bits above bit 10 all equal.
  assign imm_ok   = (&in_imm[IMMSIZE-1:11]) || !(|in_imm[IMMSIZE-1:11]);

  // Instruction word assembly per format; B immediate is in halfword units.
  always_comb begin
    word  = '0;
    op_ok = 1'b0;
    case (in_opcode)
      OP_I, OP_L: begin
        op_ok = 1'b1;
        word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_S: begin
        op_ok = 1'b1;
        word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      OP_B: begin
        op_ok = 1'b1;
        word  = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                 in_imm[3:0], in_imm[10], in_opcode};
      end
      default: begin
        op_ok = 1'b0;
        word  = '0;
      end
    endcase
  end

  // Next-state and next-output logic for the load session.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = imem_we;
    addr_d  = imem_addr;
    wdata_d = imem_wdata;
    done_d  = 1'b0;
    errf_d  = err_flag;
    errc_d  = err_count;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ptr_d   = base_addr;
          errf_d  = 1'b0;
          errc_d  = '0;
        end
      end
      S_RUN: begin
        if (wr_hs) begin
          we_d  = 1'b0;
          ptr_d = ptr_inc;
        end
        if (fire) begin
          if (op_ok && imm_ok) begin
            we_d    = 1'b1;
            addr_d  = wr_hs ? ptr_inc : ptr_q;
            wdata_d = INTRSIZE'(word);
          end else begin
            errf_d = 1'b1;
            if (err_count != '1) errc_d = err_count + ERRCNTSIZE'(1);
          end
          if (in_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wr_hs) begin
          we_d  = 1'b0;
          ptr_d = ptr_inc;
        end
        if (!imem_we || imem_ready) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err_flag   <= 1'b0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      done       <= done_d;
      err_flag   <= errf_d;
      err_count  <= errc_d;
    end
  end

endmodule

// File: tb/tb_instruction_assembler.sv
// Directed bench for instruction_assembler with hand-computed expected words.
module tb_instruction_assembler;

  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready;
  logic        done;
  logic        err_flag;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_err = 0;

  instruction_assembler dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_ready (imem_ready),
    .done       (done),
    .err_flag   (err_flag),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                      input logic last);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_imm    = imm;
    in_last   = last;
  endtask

  task automatic no_beat();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic begin_session(input logic [31:0] base);
    start     = 1'b1;
    base_addr = base;
    step();
    start     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; imem_ready = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_opcode = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
    step(); step();
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_errc", 32'(err_count), 32'd0);
    reset = 1'b0;
    step();

    // single I-type word with negative immediate
    begin_session(32'h100);
    beat(OP_I, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 1'b1);
    #1;
    chk("t1_ready", 32'(in_ready), 32'd1);
    step();
    no_beat();
    chk("t1_we", 32'(imem_we), 32'd1);
    chk("t1_addr", imem_addr, 32'h100);
    chk("t1_wdata", imem_wdata, 32'hFFF0_0293);
    chk("t1_done_early", 32'(done), 32'd0);
    step();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_we_clr", 32'(imem_we), 32'd0);
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // back-to-back L, S, B at full throughput
    begin_session(32'h0);
    beat(OP_L, 5'd6, 5'd2, 5'd0, 3'd2, 32'd8, 1'b0);
    step();
    chk("t2_l_addr", imem_addr, 32'h0);
    chk("t2_l_wdata", imem_wdata, 32'h0081_2303);
    beat(OP_S, 5'd0, 5'd2, 5'd7, 3'd2, 32'd12, 1'b0);
    step();
    chk("t2_s_addr", imem_addr, 32'h4);
    chk("t2_s_wdata", imem_wdata, 32'h0071_2623);
    beat(OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4, 1'b1);
    step();
    no_beat();
    chk("t2_b_we", 32'(imem_we), 32'd1);
    chk("t2_b_addr", imem_addr, 32'h8);
    chk("t2_b_wdata", imem_wdata, 32'h0020_8463);
    step();
    chk("t2_done", 32'(done), 32'd1);
    step();

    // out-of-range immediate and unsupported opcode are rejected
    begin_session(32'h200);
    beat(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 1'b0);
    step();
    chk("t3_no_we", 32'(imem_we), 32'd0);
    chk("t3_errf", 32'(err_flag), 32'd1);
    chk("t3_errc1", 32'(err_count), 32'd1);
    beat(7'b0110011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 1'b0);
    step();
    chk("t3_badop_we", 32'(imem_we), 32'd0);
    chk("t3_errc2", 32'(err_count), 32'd2);
    beat(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 1'b1);
    step();
    no_beat();
    chk("t3_we", 32'(imem_we), 32'd1);
    chk("t3_addr", imem_addr, 32'h200);
    chk("t3_wdata", imem_wdata, 32'h0010_0093);
    chk("t3_errf_sticky", 32'(err_flag), 32'd1);
    step();
    chk("t3_done", 32'(done), 32'd1);
    step();

    // memory back-pressure holds the pending write stable
    begin_session(32'h300);
    imem_ready = 1'b0;
    beat(OP_I, 5'd2, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0);
    step();
    beat(OP_I, 5'd3, 5'd0, 5'd0, 3'd0, 32'd6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_stall_ready", 32'(in_ready), 32'd0);
      chk("t4_stall_we", 32'(imem_we), 32'd1);
      chk("t4_stall_addr", imem_addr, 32'h300);
      chk("t4_stall_wdata", imem_wdata, 32'h0050_0113);
      step();
    end
    imem_ready = 1'b1;
    #1;
    chk("t4_ready", 32'(in_ready), 32'd1);
    step();
    no_beat();
    chk("t4_addr2", imem_addr, 32'h304);
    chk("t4_wdata2", imem_wdata, 32'h0060_0193);
    step();
    chk("t4_done", 32'(done), 32'd1);
    step();

    // address wrap at the top of the space
    begin_session(32'hFFFF_FFFC);
    beat(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 1'b0);
    step();
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    beat(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2, 1'b1);
    step();
    no_beat();
    chk("t5_addr_wrap", imem_addr, 32'h0);
    chk("t5_wdata_wrap", imem_wdata, 32'h0020_0093);
    step();
    step();

    // start ignored in RUN, then reset during DRAIN with a pending write
    begin_session(32'h400);
    start = 1'b1;
    base_addr = 32'h800;
    beat(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_F000, 1'b0);
    step();
    start = 1'b0;
    chk("t6_errc", 32'(err_count), 32'd1);
    imem_ready = 1'b0;
    beat(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3, 1'b1);
    step();
    no_beat();
    chk("t6_addr_noreload", imem_addr, 32'h400);
    chk("t6_we_pending", 32'(imem_we), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_we", 32'(imem_we), 32'd0);
    chk("t6_rst_errc", 32'(err_count), 32'd0);
    chk("t6_rst_errf", 32'(err_flag), 32'd0);
    imem_ready = 1'b1;
    beat(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3, 1'b1);
    #1;
    chk("t6_idle_ready", 32'(in_ready), 32'd0);
    step();
    no_beat();
    chk("t6_idle_no_we", 32'(imem_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
